// File: rtl/encoder_pkg.sv
// Shared opcode/funct constants and types for the RV32I
// instruction encoder. The decoder imports the same constants.
package encoder_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_SW  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FULL
  } enc_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_LW_SW   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: abstract op + fields -> RV32I word.
// Codes outside enc_op_t flag illegal and produce a zero word.
module instr_pack
  import encoder_pkg::*;
(
  input  enc_op_t     op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [11:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_LW: word_o = {imm_i, rs1_i, F3_LW_SW,
                       rd_i, OP_LOAD};
      OP_SW: word_o = {imm_i[11:5], rs2_i, rs1_i,
                       F3_LW_SW, imm_i[4:0], OP_STORE};
      OP_ADD: word_o = {F7_BASE, rs2_i, rs1_i,
                        F3_ADD_SUB, rd_i, OP_RTYPE};
      OP_SUB: word_o = {F7_SUB, rs2_i, rs1_i,
                        F3_ADD_SUB, rd_i, OP_RTYPE};
      OP_AND: word_o = {F7_BASE, rs2_i, rs1_i,
                        F3_AND, rd_i, OP_RTYPE};
      OP_OR: word_o = {F7_BASE, rs2_i, rs1_i,
                       F3_OR, rd_i, OP_RTYPE};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes requests and writes them sequentially
// into instruction memory over a held-write/ack port.
module instr_encoder
  import encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  enc_op_t       req_op,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [11:0]   req_imm,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ack,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err
);

  enc_state_t  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic        err_q;
  logic [31:0] word;
  logic        illegal;

  instr_pack u_pack (
    .op_i      (req_op),
    .rd_i      (req_rd),
    .rs1_i     (req_rs1),
    .rs2_i     (req_rs2),
    .imm_i     (req_imm),
    .word_o    (word),
    .illegal_o (illegal)
  );

  assign count_d = count_q + CW'(1);

  // clear outranks everything but reset, so an ack
  // coinciding with clear is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              err_q <= 1'b1;
            end else begin
              wdata_q <= word;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (imem_ack) begin
            count_q <= count_d;
            addr_q  <= addr_q + 32'd4;
            state_q <= (count_d == CW'(DEPTH))
                       ? ST_FULL : ST_IDLE;
          end
        end
        default: state_q <= ST_FULL;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign imem_we    = (state_q == ST_WRITE);
  assign full       = (state_q == ST_FULL);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table with a
// write scoreboard, plus hand sequences for error/full/abort.
module tb_instr_encoder;
  import encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  enc_op_t       req_op = OP_LW;
  logic [4:0]    req_rd = '0;
  logic [4:0]    req_rs1 = '0;
  logic [4:0]    req_rs2 = '0;
  logic [11:0]   req_imm = '0;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ack = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          err;

  instr_encoder #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ack   (imem_ack),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    enc_op_t     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] word;
    int          dly;
    bit          clr;
  } vec_t;

  vec_t vecs[8];
  logic [63:0] sb[$];
  int total = 0;
  int pass = 0;
  int exp_cnt = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  // scoreboard: every committed write must match the queue head
  always @(negedge clk) begin
    if (rst_n && !clear && imem_we && imem_ack) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_addr", imem_addr, e[63:32]);
        chk("sb_wdata", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic start_req(input enc_op_t op,
                           input logic [4:0] rd,
                           input logic [4:0] rs1,
                           input logic [4:0] rs2,
                           input logic [11:0] imm);
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_op = op;
    req_rd = rd;
    req_rs1 = rs1;
    req_rs2 = rs2;
    req_imm = imm;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_write(input vec_t v);
    logic [31:0] a;
    a = BASE + 32'(exp_cnt) * 32'd4;
    sb.push_back({a, v.word});
    start_req(v.op, v.rd, v.rs1, v.rs2, v.imm);
    chk("we_rise", {31'd0, imem_we}, 32'd1);
    chk("ready_low", {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < v.dly; k++) begin
      tick();
      chk("we_held", {31'd0, imem_we}, 32'd1);
      chk("wdata_stable", imem_wdata, v.word);
      chk("addr_stable", imem_addr, a);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    exp_cnt++;
    chk("we_drop", {31'd0, imem_we}, 32'd0);
    chk("count", 32'(count), 32'(exp_cnt));
    chk("full", {31'd0, full},
        {31'd0, exp_cnt == DEPTH});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{OP_ADD, 5'd1, 5'd2, 5'd3, 12'h7FF,
                32'h003100B3, 1, 1'b0};
    vecs[1] = '{OP_LW, 5'd5, 5'd0, 5'd0, 12'h004,
                32'h00402283, 0, 1'b1};
    vecs[2] = '{OP_SW, 5'd0, 5'd0, 5'd5, 12'h008,
                32'h00502423, 0, 1'b0};
    vecs[3] = '{OP_SUB, 5'd1, 5'd2, 5'd3, 12'hFFF,
                32'h403100B3, 0, 1'b0};
    vecs[4] = '{OP_AND, 5'd1, 5'd2, 5'd3, 12'h000,
                32'h003170B3, 2, 1'b0};
    vecs[5] = '{OP_OR, 5'd1, 5'd2, 5'd3, 12'h123,
                32'h003160B3, 0, 1'b0};
    vecs[6] = '{OP_LW, 5'd31, 5'd31, 5'd7, 12'hFFF,
                32'hFFFFAF83, 1, 1'b0};
    vecs[7] = '{OP_SW, 5'd9, 5'd1, 5'd2, 12'h800,
                32'h8020A023, 0, 1'b0};

    // reset values while held in reset
    #3;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // table-driven encodings and addresses
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr || exp_cnt == DEPTH) pulse_clear();
      do_write(vecs[i]);
      if (i == 0)
        chk("ready_after_t1", {31'd0, req_ready}, 32'd1);
    end
    pulse_clear();

    // illegal op: sticky err, no write, then recovery
    req_valid = 1'b1;
    req_op = enc_op_t'(3'd7);
    tick();
    req_valid = 1'b0;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_we", {31'd0, imem_we}, 32'd0);
    chk("ill_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("ill_we2", {31'd0, imem_we}, 32'd0);
    chk("ill_count", 32'(count), 32'd0);
    do_write(vecs[3]);
    chk("err_sticky", {31'd0, err}, 32'd1);
    pulse_clear();
    chk("err_cleared", {31'd0, err}, 32'd0);

    // fill to DEPTH, 5th request ignored
    for (int i = 0; i < DEPTH; i++) do_write(vecs[2 + i]);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_op = enc_op_t'(3'd6);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_no_we", {31'd0, imem_we}, 32'd0);
    end
    req_valid = 1'b0;
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_no_err", {31'd0, err}, 32'd0);
    pulse_clear();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_addr", imem_addr, BASE);
    chk("clr_ready", {31'd0, req_ready}, 32'd1);

    // clear mid-write with coincident ack
    start_req(OP_ADD, 5'd1, 5'd2, 5'd3, 12'h0);
    chk("abort_we_up", {31'd0, imem_we}, 32'd1);
    clear = 1'b1;
    imem_ack = 1'b1;
    tick();
    clear = 1'b0;
    imem_ack = 1'b0;
    exp_cnt = 0;
    chk("abort_clr_we", {31'd0, imem_we}, 32'd0);
    chk("abort_clr_count", 32'(count), 32'd0);
    do_write(vecs[5]);

    // async reset mid-write with coincident ack
    pulse_clear();
    start_req(OP_SUB, 5'd1, 5'd2, 5'd3, 12'h0);
    imem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort_rst_we", {31'd0, imem_we}, 32'd0);
    chk("abort_rst_count", 32'(count), 32'd0);
    chk("abort_rst_addr", imem_addr, BASE);
    chk("abort_rst_wdata", imem_wdata, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    do_write(vecs[0]);

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
